// File: rtl/ttl_universal_reg_pkg.sv
// Shared definitions for the TTL-style universal register.
// Mode encoding and legal width bounds.
package ttl_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD     = 3'd0,
        MODE_LOAD     = 3'd1,
        MODE_SHIFT_UP = 3'd2,
        MODE_SHIFT_DN = 3'd3,
        MODE_ROT_UP   = 3'd4,
        MODE_ROT_DN   = 3'd5,
        MODE_CNT_UP   = 3'd6,
        MODE_CNT_DN   = 3'd7
    } ttl_mode_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/ttl_universal_reg_if.sv
// Control/data bundle for the universal register.
// The master drives controls, the slave returns register state.
interface ttl_universal_reg_if #(
    parameter int WIDTH = 8
);
    logic             clr_n;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             ser_lo;
    logic             ser_hi;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;

    modport master (
        output clr_n, en, mode, d, ser_lo, ser_hi,
        input  q, qbar, tc
    );

    modport slave (
        input  clr_n, en, mode, d, ser_lo, ser_hi,
        output q, qbar, tc
    );
endinterface

// File: rtl/ttl_universal_reg.sv
// Universal shift/rotate/count register, 74x194/74x163 style.
// tc is combinational so stages cascade without extra latency.
module ttl_universal_reg
    import ttl_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_lo,
    input  logic             ser_hi,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("ttl_universal_reg: WIDTH must be 2..32");
        end
    endgenerate

    ttl_mode_t m;
    assign m = ttl_mode_t'(mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (!clr_n) begin
            q <= '0;
        end else if (m == MODE_LOAD) begin
            q <= d;
        end else if (en) begin
            case (m)
                MODE_SHIFT_UP: q <= {q[WIDTH-2:0], ser_lo};
                MODE_SHIFT_DN: q <= {ser_hi, q[WIDTH-1:1]};
                MODE_ROT_UP:   q <= {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROT_DN:   q <= {q[0], q[WIDTH-1:1]};
                MODE_CNT_UP:   q <= q + 1'b1;
                MODE_CNT_DN:   q <= q - 1'b1;
                default:       q <= q;
            endcase
        end
    end

    assign qbar = ~q;

    assign tc = en & (((m == MODE_CNT_UP) & (&q)) |
                      ((m == MODE_CNT_DN) & ~(|q)));

endmodule

// File: doc/ttl_universal_reg.md
TTL_UNIVERSAL_REG -- requirements
Module: ttl_universal_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded by rst.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port clr_n  input  1  synchronous clear, active low.
REQ-006 SHALL have port en  input  1  operation enable for shift/rotate/count modes.
REQ-007 SHALL have port mode  input  3  operation select; encoding per REQ-015.
REQ-008 SHALL have port d  input  WIDTH  parallel load data.
REQ-009 SHALL have port ser_lo  input  1  serial data entering bit 0 on shift-up.
REQ-010 SHALL have port ser_hi  input  1  serial data entering bit WIDTH-1 on shift-down.
REQ-011 SHALL have port q  output  WIDTH  register contents.
REQ-012 SHALL have port qbar  output  WIDTH  bitwise complement of q at all times.
REQ-013 SHALL have port tc  output  1  terminal count / ripple carry, combinational.

Function
REQ-014 Priority per rising edge: rst, then clr_n low, then mode LOAD, then en-gated modes; at most one action per cycle.
REQ-015 mode encoding: 0 HOLD; 1 LOAD (q <= d); 2 SHIFT_UP (q <= {q[WIDTH-2:0], ser_lo}); 3 SHIFT_DN (q <= {ser_hi, q[WIDTH-1:1]}); 4 ROT_UP (q[0] <= q[WIDTH-1]); 5 ROT_DN (q[WIDTH-1] <= q[0]); 6 CNT_UP (q <= q+1); 7 CNT_DN (q <= q-1).
REQ-016 LOAD SHALL take effect regardless of en.
REQ-017 Modes 2..7 SHALL act only when en=1; with en=0 q holds.
REQ-018 HOLD SHALL leave q unchanged regardless of en.
REQ-019 Counting SHALL be modulo 2^WIDTH: all-ones +1 -> 0, 0 -1 -> all-ones, no saturation.
REQ-020 tc SHALL be 1 iff en=1 and ((mode=CNT_UP and q all-ones) or (mode=CNT_DN and q=0)); 0 in all other modes.
REQ-021 tc SHALL depend only on current q, en, mode (no registered delay), so cascaded stages increment on the same edge the lower stage wraps.
REQ-022 clr_n low SHALL force q to 0 on the next edge irrespective of mode, en, d.
REQ-023 Latency: every update visible on q and qbar in the cycle after the capturing edge; no pipelining.
REQ-024 Mode changes SHALL take effect on the first edge they are stable for; no internal state beyond q.

Reset
REQ-025 rst=1 at a rising edge SHALL set q=RESET_VAL, qbar=~RESET_VAL, overriding clr_n, LOAD, en.
REQ-026 Reset asserted mid-count or mid-shift SHALL discard the operation; counting resumes from RESET_VAL after release.
REQ-027 tc after reset SHALL follow REQ-020 from RESET_VAL (e.g. RESET_VAL all-ones, CNT_UP, en=1 -> tc=1 immediately).

Structure
REQ-028 Shared package ttl_pkg SHALL hold the mode enum typedef (ttl_mode_t, 3 bits) and its named constants.
REQ-029 No sub-module SHALL be required; one clocked process for q, continuous assignments for qbar and tc.
REQ-030 WIDTH outside 2..32 SHALL fail elaboration.

Verification (WIDTH=8, RESET_VAL=0 unless noted)
REQ-031 rst=1 one edge -> q=0x00, qbar=0xFF, tc=0; with RESET_VAL=0xA5 -> q=0xA5, qbar=0x5A.
REQ-032 LOAD d=0xFE, en=0 -> q=0xFE; then CNT_UP en=1: tc=0, q=0xFF, tc=1, next edge q=0x00, tc=0.
REQ-033 q=0x01, CNT_DN en=1 -> q=0x00 with tc=1, next edge q=0xFF tc=0; en=0 for 3 edges -> q stays 0xFF.
REQ-034 q=0x81, SHIFT_UP ser_lo=1 -> 0x03; SHIFT_DN ser_hi=0 from 0x81 -> 0x40; ROT_UP 0x81 -> 0x03; ROT_DN 0x81 -> 0xC0.
REQ-035 q=0x55, mode=LOAD d=0x33 with clr_n=0 -> q=0x00; same edge with rst=1 and RESET_VAL=0xA5 -> q=0xA5.
REQ-036 Cascade two instances (low.tc -> high.en, both CNT_UP): from 0x00FF one edge -> 0x0100; qbar==~q checked every cycle.
